instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch-side initiator for the combinational instruction memory: drives the byte address (PC) and captures the returned 16-bit Instruction.
- Holds fetched words with their addresses in a small prefetch queue and hands them to decode over a valid/ready handshake.
- Handles branch redirect with flush, and stops fetching on a HALT opcode.
- Sits between instructionMemory and the decode stage of the 16-bit CPU.

Parameters:
- DEPTH, 2, prefetch queue entries; power of two, 2..8.
- RESET_PC, 16'h0000, PC value loaded on reset; must be even.
- HALT_OPCODE, 4'hF, Instruction[15:12] value that stops fetching.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- PC  output  16  byte address to instructionMemory; always even.
- Instruction  input  16  combinational memory read data for the current PC.
- BranchTaken  input  1  redirect request; sampled at the clock edge.
- BranchTarget  input  16  redirect address; bit 0 is ignored.
- FetchValid  output  1  queue head holds a valid instruction.
- FetchReady  input  1  decode accepts the head.
- IR  output  16  head instruction.
- IRPC  output  16  address of the head instruction.
- Halted  output  1  fetch stopped by HALT_OPCODE.

Behaviour:
- Reset (Reset=0, asynchronous):
  - PC=RESET_PC; queue empty; FetchValid=0, IR=0, IRPC=0, Halted=0.
  - State=FETCH.
  - Reset asserted mid-operation discards all queue contents immediately.
- States:
  - FETCH: push enabled.
  - HALTED: no push, PC frozen.
- Push (FETCH, queue not full, BranchTaken=0):
  - Write {PC, Instruction} at tail; PC <= PC+2.
  - 16-bit wrap: 16'hFFFE -> 16'h0000.
  - "Full" is registered occupancy == DEPTH. A pop in the same cycle does not enable the push; there is no combinational FetchReady -> PC path.
- Pop: on FetchValid & FetchReady at the edge, advance the head.
- FetchValid, IR and IRPC reflect the queue head combinationally from registered storage. IR and IRPC are 0 when empty.
- Push and pop in the same cycle keep occupancy unchanged.
- Latency: a word fetched at PC=A appears with IRPC=A on the cycle after the push edge, provided the queue was empty.
- Throughput: one instruction per cycle with FetchReady held at 1.
- HALT detection:
  - If the pushed Instruction[15:12]==HALT_OPCODE, the word is still pushed and delivered.
  - Same edge: state -> HALTED, Halted=1, PC stays at halt address+2.
- Redirect (BranchTaken=1 at edge, either state):
  - Flush queue (occupancy 0); PC <= {BranchTarget[15:1],1'b0}.
  - No push or pop takes effect that cycle.
  - State -> FETCH, Halted=0.
  - Redirect has priority over push, pop and HALT detection.
- Empty and FetchReady=1: no effect. Full and FetchReady=0: PC and queue hold, outputs stable.
- Occupancy counter is $clog2(DEPTH)+1 bits wide; head and tail pointers wrap modulo DEPTH.

Decomposition:
- Shared cpu package:
  - ISA opcode constants, including HALT opcode 4'hF.
  - Instruction width 16 and address width 16.
  - PC_STEP=2.
  - Fetch state enum {FETCH, HALTED}.
- One sub-module: fetch_queue, a DEPTH-entry FIFO of 32-bit {pc, instr} with push/pop/flush and full/empty flags, reset asynchronous active-low.

Test Plan:
- Reset release with FetchReady=1 and memory word at byte address N = 16'h1000+N:
  - FetchValid rises one cycle after the first edge.
  - IRPC sequence 0,2,4,6 on consecutive cycles; IR = 16'h1000,16'h1002,16'h1004,16'h1006.
- Backpressure (FetchReady=0 from reset, DEPTH=2):
  - After two edges the queue is full, PC holds 16'h0004, IRPC stays 16'h0000, IR stays 16'h1000.
  - Raising FetchReady resumes the order 0,2,4.
- Redirect with BranchTarget=16'h0011 while the queue is full:
  - Next cycle FetchValid=0 and PC=16'h0010.
  - Following cycle IRPC=16'h0010; no stale entry is delivered.
- HALT (word at 16'h0006 = 16'hF000):
  - IR=16'hF000 is delivered; Halted=1; PC freezes at 16'h0008; queue drains and FetchValid=0.
  - BranchTaken to 16'h0020 clears Halted and fetching resumes at 16'h0020.
- Wrap: redirect to 16'hFFFE -> IRPC 16'hFFFE then 16'h0000.
- Reset asserted between edges with 2 entries queued:
  - FetchValid=0, PC=RESET_PC immediately, before the next edge.
  - After release, fetch restarts at 16'h0000.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU definitions for the fetch side: datapath widths, ISA opcodes,
// the PC increment and the fetch state encoding.
package instruction_fetch_unit_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;
    localparam int ENTRY_W = ADDR_W + INSTR_W;

    localparam logic [ADDR_W-1:0] PC_STEP       = 16'd2;
    localparam logic [ADDR_W-1:0] PC_ALIGN_MASK = 16'hFFFE;

    // ISA major opcodes (Instruction[15:12])
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_LOAD = 4'h8;
    localparam logic [3:0] OP_STOR = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1:INSTR_W-4];
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// DEPTH-entry FIFO of {pc, instr} words; head is read combinationally and
// reads as zero while empty. Flush discards everything and wins over push/pop.
module fetch_queue
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    input  logic               flush,
    output logic [ENTRY_W-1:0] head_data,
    output logic               full,
    output logic               empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ENTRY_W-1:0] storage_reg [DEPTH];
    logic [PTR_W-1:0]   head_reg, head_next;
    logic [PTR_W-1:0]   tail_reg, tail_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap
            if (do_push) tail_next = tail_reg + PTR_W'(1);
            if (do_pop)  head_next = head_reg + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Entry contents need no reset: occupancy alone decides what is visible
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (do_push && (tail_reg == PTR_W'(gi))) begin
                storage_reg[gi] <= push_data;
            end
        end
    end

    assign head_data = empty ? '0 : storage_reg[head_reg];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch initiator: drives PC into the combinational instruction memory, queues
// {pc, instr} for decode, handles branch redirect/flush and stops on HALT.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                DEPTH       = 2,
    parameter logic [ADDR_W-1:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]        HALT_OPCODE = OP_HALT
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic [ADDR_W-1:0]  PC,
    input  logic [INSTR_W-1:0] Instruction,
    input  logic               BranchTaken,
    input  logic [ADDR_W-1:0]  BranchTarget,
    output logic               FetchValid,
    input  logic               FetchReady,
    output logic [INSTR_W-1:0] IR,
    output logic [ADDR_W-1:0]  IRPC,
    output logic               Halted
);

    fetch_state_e      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              q_push;
    logic              q_pop;
    logic              q_flush;
    logic              q_full;
    logic              q_empty;
    logic [ENTRY_W-1:0] q_head;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg <= FETCH;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    // Push depends only on registered fullness, so FetchReady never reaches PC
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        q_push     = 1'b0;
        q_pop      = 1'b0;
        q_flush    = 1'b0;
        if (BranchTaken) begin
            q_flush    = 1'b1;
            pc_next    = BranchTarget & PC_ALIGN_MASK;
            state_next = FETCH;
        end else begin
            q_pop = !q_empty && FetchReady;
            if ((state_reg == FETCH) && !q_full) begin
                q_push  = 1'b1;
                pc_next = pc_reg + PC_STEP;
                if (opcode_of(Instruction) == HALT_OPCODE) begin
                    state_next = HALTED;
                end
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clk       (Clock),
        .rst_n     (Reset),
        .push      (q_push),
        .push_data ({pc_reg, Instruction}),
        .pop       (q_pop),
        .flush     (q_flush),
        .head_data (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign PC         = pc_reg;
    assign FetchValid = !q_empty;
    assign IRPC       = q_head[ENTRY_W-1:INSTR_W];
    assign IR         = q_head[INSTR_W-1:0];
    assign Halted     = (state_reg == HALTED);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: directed test-plan scenarios plus randomized traffic,
// all checked against a queue-based behavioural model of the fetch unit.
module tb_instruction_fetch_unit;

    localparam int DEPTH = 2;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] PC;
    logic [15:0] Instruction;
    logic        BranchTaken = 1'b0;
    logic [15:0] BranchTarget = 16'h0000;
    logic        FetchValid;
    logic        FetchReady = 1'b1;
    logic [15:0] IR;
    logic [15:0] IRPC;
    logic        Halted;

    int check_count = 0;
    int error_count = 0;

    // Memory image: mode 0 = 16'h1000+addr (optional HALT at 6), mode 1 = random table
    int          mem_mode = 0;
    bit          halt_at6 = 1'b0;
    logic [15:0] rnd_mem [256];

    // Reference model state
    logic [31:0] mq[$];
    logic [15:0] m_pc;
    bit          m_halted;

    instruction_fetch_unit #(
        .DEPTH       (DEPTH),
        .RESET_PC    (16'h0000),
        .HALT_OPCODE (4'hF)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .PC           (PC),
        .Instruction  (Instruction),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .FetchValid   (FetchValid),
        .FetchReady   (FetchReady),
        .IR           (IR),
        .IRPC         (IRPC),
        .Halted       (Halted)
    );

    always #5 Clock = ~Clock;

    function automatic logic [15:0] mem_word(input logic [15:0] addr);
        if (mem_mode == 1) return rnd_mem[addr[8:1]];
        if (halt_at6 && addr == 16'h0006) return 16'hF000;
        return 16'h1000 + addr;
    endfunction

    always_comb Instruction = mem_word(PC);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc     = 16'h0000;
        m_halted = 1'b0;
    endtask

    // Compare outputs with the model, apply one clock edge to both, land at edge+1
    task automatic step();
        logic [15:0] w;
        bit          was_full;
        check_eq("valid",  {31'd0, FetchValid}, {31'd0, mq.size() > 0});
        check_eq("ir",     {16'd0, IR},   (mq.size() > 0) ? {16'd0, mq[0][15:0]}  : 32'd0);
        check_eq("irpc",   {16'd0, IRPC}, (mq.size() > 0) ? {16'd0, mq[0][31:16]} : 32'd0);
        check_eq("pc",     {16'd0, PC},   {16'd0, m_pc});
        check_eq("halted", {31'd0, Halted}, {31'd0, m_halted});
        if (BranchTaken) begin
            mq.delete();
            m_pc     = {BranchTarget[15:1], 1'b0};
            m_halted = 1'b0;
        end else begin
            was_full = (mq.size() == DEPTH);
            if (mq.size() > 0 && FetchReady) void'(mq.pop_front());
            if (!m_halted && !was_full) begin
                w = mem_word(m_pc);
                mq.push_back({m_pc, w});
                if (w[15:12] == 4'hF) m_halted = 1'b1;
                m_pc = m_pc + 16'd2;
            end
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        #1;
        model_reset();
        @(posedge Clock);
        #1;
        Reset = 1'b1;
    endtask

    task automatic redirect(input logic [15:0] tgt);
        BranchTaken  = 1'b1;
        BranchTarget = tgt;
        step();
        BranchTaken  = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        check_eq("rst_pc",     {16'd0, PC}, 32'h0);
        check_eq("rst_valid",  {31'd0, FetchValid}, 32'd0);
        check_eq("rst_ir",     {16'd0, IR}, 32'h0);
        check_eq("rst_irpc",   {16'd0, IRPC}, 32'h0);
        check_eq("rst_halted", {31'd0, Halted}, 32'd0);
        @(posedge Clock);
        #1;
        Reset = 1'b1;

        // Streaming with FetchReady=1
        FetchReady = 1'b1;
        step();
        check_eq("first_valid", {31'd0, FetchValid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_eq("stream_irpc", {16'd0, IRPC}, 32'(2 * i));
            check_eq("stream_ir",   {16'd0, IR},   32'h1000 + 32'(2 * i));
            step();
        end

        // Backpressure from reset
        do_reset();
        FetchReady = 1'b0;
        step();
        step();
        check_eq("bp_pc",   {16'd0, PC},   32'h0004);
        check_eq("bp_irpc", {16'd0, IRPC}, 32'h0000);
        check_eq("bp_ir",   {16'd0, IR},   32'h1000);
        step();
        check_eq("bp_hold", {16'd0, PC},   32'h0004);
        FetchReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_order", {16'd0, IRPC}, 32'(2 * i));
            step();
        end

        // Redirect while full
        FetchReady = 1'b0;
        step();
        step();
        step();
        redirect(16'h0011);
        check_eq("br_valid", {31'd0, FetchValid}, 32'd0);
        check_eq("br_pc",    {16'd0, PC}, 32'h0010);
        step();
        check_eq("br_irpc",  {16'd0, IRPC}, 32'h0010);
        FetchReady = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // HALT at address 6
        halt_at6 = 1'b1;
        do_reset();
        FetchReady = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check_eq("halt_ir", {16'd0, IR}, 32'hF000);
        for (int i = 0; i < 4; i++) step();
        check_eq("halt_flag",  {31'd0, Halted}, 32'd1);
        check_eq("halt_pc",    {16'd0, PC}, 32'h0008);
        check_eq("halt_drain", {31'd0, FetchValid}, 32'd0);
        redirect(16'h0020);
        check_eq("unhalt", {31'd0, Halted}, 32'd0);
        check_eq("unhalt_pc", {16'd0, PC}, 32'h0020);
        step();
        check_eq("unhalt_irpc", {16'd0, IRPC}, 32'h0020);
        halt_at6 = 1'b0;

        // 16-bit PC wrap
        redirect(16'hFFFE);
        step();
        check_eq("wrap_hi", {16'd0, IRPC}, 32'hFFFE);
        step();
        check_eq("wrap_lo", {16'd0, IRPC}, 32'h0000);
        step();

        // Asynchronous reset between edges with two entries queued
        do_reset();
        FetchReady = 1'b0;
        step();
        step();
        check_eq("pre_areset", {31'd0, FetchValid}, 32'd1);
        Reset = 1'b0;
        #1;
        check_eq("areset_valid", {31'd0, FetchValid}, 32'd0);
        check_eq("areset_pc",    {16'd0, PC}, 32'h0000);
        model_reset();
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        FetchReady = 1'b1;
        step();
        check_eq("areset_restart", {16'd0, IRPC}, 32'h0000);
        step();

        // Randomized traffic against the model
        mem_mode = 1;
        for (int i = 0; i < 256; i++) begin
            rnd_mem[i] = 16'($urandom);
            if ($urandom_range(7) == 0) rnd_mem[i][15:12] = 4'hF;
            else if (rnd_mem[i][15:12] == 4'hF) rnd_mem[i][15:12] = 4'h0;
        end
        for (int i = 0; i < 3000; i++) begin
            FetchReady   = ($urandom_range(9) < 7);
            BranchTaken  = ($urandom_range(19) == 0);
            BranchTarget = 16'($urandom);
            step();
        end
        BranchTaken = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
